instr_encoder: RTL and testbench

//  Inverse of the immediate decode path: packs decoded fields (format, opcode, regs, funct, 32-bit imm)

---
 rtl/instr_encoder_if.sv | 30 +++
 rtl/instr_encoder.sv | 142 ++++++++++++++
 tb/tb_instr_encoder.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Field-bundle input and encoded-word output handshakes of the instruction encoder.
interface instr_encoder_if #(
   parameter int unsigned ADDR_W = 32
) ();
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        fmt;
   logic [6:0]        opcode;
   logic [4:0]        rd;
   logic [4:0]        rs1;
   logic [4:0]        rs2;
   logic [2:0]        funct3;
   logic [6:0]        funct7;
   logic [31:0]       imm;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_instr;
   logic [ADDR_W-1:0] out_addr;
   logic              out_err;

   modport master (
      output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
      input  in_ready, out_valid, out_instr, out_addr, out_err
   );

   modport slave (
      input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
      output in_ready, out_valid, out_instr, out_addr, out_err
   );
endinterface

// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields into instruction words and queues them, address-tagged,
// for the instruction-memory loader. Unrepresentable immediates are flagged per entry.
module instr_encoder #(
   parameter int unsigned       DEPTH     = 4,
   parameter int unsigned       ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              base_load,
   input  logic [ADDR_W-1:0] base_addr,
   output logic [7:0]        err_count,
   instr_encoder_if.slave    bus
);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

   typedef struct packed {
      logic              err;
      logic [ADDR_W-1:0] addr;
      logic [31:0]       instr;
   } entry_t;

   entry_t            mem_q [DEPTH];
   entry_t            mem_n [DEPTH];
   entry_t            head_n;
   logic [PTR_W-1:0]  wr_q, wr_n, rd_q, rd_n;
   logic [CNT_W-1:0]  cnt_q, cnt_n;
   logic [ADDR_W-1:0] addr_q, addr_n, tag;
   logic [7:0]        errc_n;
   logic [31:0]       enc_word;
   logic              enc_err;
   logic              fits12, fits13, fits21;
   logic              accept, pop;

   assign accept = bus.in_valid & bus.in_ready;
   assign pop    = bus.out_valid & bus.out_ready;

   // Signed-range checks: upper bits must be a pure sign extension.
   assign fits12 = (bus.imm[31:11] == {21{bus.imm[31]}});
   assign fits13 = (bus.imm[31:12] == {20{bus.imm[31]}});
   assign fits21 = (bus.imm[31:20] == {12{bus.imm[31]}});

   // Field packing; erroneous immediates are still truncated into the word.
   always_comb begin
      enc_word = '0;
      enc_err  = 1'b0;
      case (bus.fmt)
         3'd0: enc_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
         3'd1: begin
            enc_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
            enc_err  = ~fits12;
         end
         3'd2: begin
            enc_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
            enc_err  = ~fits12;
         end
         3'd3: begin
            enc_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                        bus.imm[4:1], bus.imm[11], bus.opcode};
            enc_err  = ~fits13 | bus.imm[0];
         end
         3'd4: begin
            enc_word = {bus.imm[31:12], bus.rd, bus.opcode};
            enc_err  = (bus.imm[11:0] != 12'd0);
         end
         3'd5: begin
            enc_word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                        bus.rd, bus.opcode};
            enc_err  = ~fits21 | bus.imm[0];
         end
         default: begin
            enc_word = 32'h0000_0013;
            enc_err  = 1'b1;
         end
      endcase
   end

   // Next state of address counter, error counter and FIFO.
   always_comb begin
      mem_n  = mem_q;
      wr_n   = wr_q;
      rd_n   = rd_q;
      cnt_n  = cnt_q;
      addr_n = addr_q;
      errc_n = err_count;
      tag    = base_load ? base_addr : addr_q;

      if (accept)         addr_n = tag + ADDR_W'(4);
      else if (base_load) addr_n = base_addr;

      if (accept && enc_err && (err_count != 8'hFF)) errc_n = err_count + 8'd1;

      if (flush) begin
         wr_n  = '0;
         rd_n  = '0;
         cnt_n = '0;
      end else begin
         if (accept) begin
            mem_n[wr_q] = '{err: enc_err, addr: tag, instr: enc_word};
            wr_n        = wr_q + PTR_W'(1);
         end
         if (pop) rd_n = rd_q + PTR_W'(1);
         case ({accept, pop})
            2'b10:   cnt_n = cnt_q + CNT_W'(1);
            2'b01:   cnt_n = cnt_q - CNT_W'(1);
            default: cnt_n = cnt_q;
         endcase
      end
      head_n = mem_n[rd_n];
   end

   // Outputs are registered from the post-update head so they appear one cycle after accept.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
         wr_q          <= '0;
         rd_q          <= '0;
         cnt_q         <= '0;
         addr_q        <= BASE_ADDR;
         err_count     <= 8'd0;
         bus.in_ready  <= 1'b1;
         bus.out_valid <= 1'b0;
         bus.out_instr <= 32'd0;
         bus.out_addr  <= '0;
         bus.out_err   <= 1'b0;
      end else begin
         mem_q         <= mem_n;
         wr_q          <= wr_n;
         rd_q          <= rd_n;
         cnt_q         <= cnt_n;
         addr_q        <= addr_n;
         err_count     <= errc_n;
         bus.in_ready  <= (cnt_n != CNT_W'(DEPTH));
         bus.out_valid <= (cnt_n != '0);
         bus.out_instr <= head_n.instr;
         bus.out_addr  <= head_n.addr;
         bus.out_err   <= head_n.err;
      end
   end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder with hand-computed expected words.
module tb_instr_encoder;
   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        base_load;
   logic [31:0] base_addr;
   logic [7:0]  err_count;
   int          checks   = 0;
   int          failures = 0;
   logic [31:0] exp_addr;

   instr_encoder_if #(.ADDR_W(32)) bus ();

   instr_encoder #(.DEPTH(4), .ADDR_W(32), .BASE_ADDR(32'h0)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .base_load (base_load),
      .base_addr (base_addr),
      .err_count (err_count),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [31:0] imm);
      bus.fmt = f; bus.opcode = op; bus.rd = rd; bus.rs1 = rs1; bus.rs2 = rs2;
      bus.funct3 = f3; bus.funct7 = f7; bus.imm = imm;
   endtask

   // Presents one bundle for a single edge; outputs are sampled 1 ns after it.
   task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
      set_fields(f, op, rd, rs1, rs2, f3, f7, imm);
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   function automatic logic [31:0] addi_word(input int k);
      return (32'(k) << 20) | (32'(k) << 7) | 32'h13;
   endfunction

   initial begin
      rst = 1'b1; flush = 1'b0; base_load = 1'b0; base_addr = '0;
      bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      set_fields(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      tick(); tick();
      rst = 1'b0;
      check("rst_valid", bus.out_valid, 0);
      check("rst_instr", bus.out_instr, 0);
      check("rst_addr", bus.out_addr, 0);
      check("rst_err", bus.out_err, 0);
      check("rst_errcnt", err_count, 0);
      check("rst_ready", bus.in_ready, 1);

      // I-format with one-cycle latency
      exp_addr = 32'h0;
      drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      check("i_valid", bus.out_valid, 1);
      check("i_instr", bus.out_instr, 32'h0050_0093);
      check("i_err", bus.out_err, 0);
      check("i_addr", bus.out_addr, exp_addr);
      exp_addr += 4;

      drive(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
      check("s_instr", bus.out_instr, 32'h0020_A423);
      check("s_addr", bus.out_addr, exp_addr); exp_addr += 4;
      drive(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd4);
      check("b_instr", bus.out_instr, 32'hFE00_0EE3);
      check("b_addr", bus.out_addr, exp_addr); exp_addr += 4;
      drive(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
      check("j_instr", bus.out_instr, 32'h0010_00EF);
      check("j_err", bus.out_err, 0);
      check("j_addr", bus.out_addr, exp_addr); exp_addr += 4;
      drive(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
      check("u_instr", bus.out_instr, 32'h1234_52B7);
      check("u_addr", bus.out_addr, exp_addr); exp_addr += 4;
      drive(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'd0);
      check("r_instr", bus.out_instr, 32'h4020_81B3); exp_addr += 4;

      // Error rules and range boundaries
      drive(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
      check("i_hi_err", bus.out_err, 1);
      check("i_hi_instr", bus.out_instr, 32'h8000_0013); exp_addr += 4;
      drive(3'd1, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, -32'sd2048);
      check("i_lo_ok", bus.out_err, 0);
      check("i_lo_instr", bus.out_instr, 32'h8000_0013); exp_addr += 4;
      drive(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
      check("b_odd_err", bus.out_err, 1); exp_addr += 4;
      drive(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd4094);
      check("b_max_ok", bus.out_err, 0); exp_addr += 4;
      drive(3'd5, 7'h6F, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0000);
      check("j_hi_err", bus.out_err, 1); exp_addr += 4;
      drive(3'd4, 7'h37, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0000_0001);
      check("u_low_err", bus.out_err, 1); exp_addr += 4;
      drive(3'd7, 7'h33, 5'd9, 5'd9, 5'd9, 3'd7, 7'h7F, 32'd0);
      check("fmt7_err", bus.out_err, 1);
      check("fmt7_instr", bus.out_instr, 32'h0000_0013);
      check("fmt7_addr", bus.out_addr, exp_addr); exp_addr += 4;
      check("errcnt5", err_count, 5);

      // Flush with three entries plus a dropped (erroneous) accept
      tick();
      check("drained", bus.out_valid, 0);
      bus.out_ready = 1'b0;
      for (int k = 1; k <= 3; k++) drive(3'd1, 7'h13, 5'(k), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k));
      check("fl_pre_valid", bus.out_valid, 1);
      check("fl_pre_head", bus.out_instr, addi_word(1));
      exp_addr += 12;
      flush = 1'b1;
      drive(3'd6, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      flush = 1'b0;
      exp_addr += 4;
      check("fl_valid", bus.out_valid, 0);
      check("fl_ready", bus.in_ready, 1);
      check("fl_errcnt", err_count, 6);
      bus.out_ready = 1'b1;
      drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
      check("fl_next_addr", bus.out_addr, exp_addr); exp_addr += 4;
      check("fl_next_valid", bus.out_valid, 1);

      // Saturation of the error counter
      for (int k = 0; k < 300; k++) begin
         drive(3'd6, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
         exp_addr += 4;
      end
      check("errcnt_sat", err_count, 255);
      check("sat_addr", bus.out_addr, exp_addr - 4);

      // Backpressure: DEPTH+1 offered, last one refused, head stable, in-order drain
      tick();
      bus.out_ready = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         set_fields(3'd1, 7'h13, 5'(k), 5'd0, 5'd0, 3'd0, 7'd0, 32'(k));
         bus.in_valid = 1'b1;
         tick();
      end
      bus.in_valid = 1'b0;
      check("bp_ready", bus.in_ready, 0);
      check("bp_head", bus.out_instr, addi_word(1));
      tick(); tick();
      check("bp_hold_instr", bus.out_instr, addi_word(1));
      check("bp_hold_addr", bus.out_addr, exp_addr);
      check("bp_hold_valid", bus.out_valid, 1);
      bus.out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         check($sformatf("bp_drain%0d", k), bus.out_instr, addi_word(k));
         check($sformatf("bp_addr%0d", k), bus.out_addr, exp_addr);
         exp_addr += 4;
         tick();
      end
      check("bp_empty", bus.out_valid, 0);
      check("bp_ready_again", bus.in_ready, 1);

      // Base load with accept, base load alone, wrap at 2^32
      base_load = 1'b1; base_addr = 32'h100;
      drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
      base_load = 1'b0;
      check("bl_addr0", bus.out_addr, 32'h100);
      drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
      check("bl_addr1", bus.out_addr, 32'h104);
      drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
      check("bl_addr2", bus.out_addr, 32'h108);
      base_load = 1'b1; base_addr = 32'h200;
      tick();
      base_load = 1'b0;
      drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
      check("bl_alone", bus.out_addr, 32'h200);
      base_load = 1'b1; base_addr = 32'hFFFF_FFFC;
      drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
      base_load = 1'b0;
      check("wrap_top", bus.out_addr, 32'hFFFF_FFFC);
      drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
      check("wrap_zero", bus.out_addr, 32'h0);

      // Reset in the middle of a run with entries queued
      bus.out_ready = 1'b0;
      drive(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
      drive(3'd7, 7'h13, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mr_valid", bus.out_valid, 0);
      check("mr_instr", bus.out_instr, 0);
      check("mr_addr", bus.out_addr, 0);
      check("mr_err", bus.out_err, 0);
      check("mr_errcnt", err_count, 0);
      check("mr_ready", bus.in_ready, 1);
      bus.out_ready = 1'b1;
      drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      check("mr_addr_base", bus.out_addr, 32'h0);
      check("mr_instr_new", bus.out_instr, 32'h0050_0093);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
